// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - byte-addressed data memory responder with wait states
// Little-endian word storage; byte/halfword/word access with alignment and range checking.
module data_mem_responder #(
    parameter int WIDTH       = 32,
    parameter int ADDR_W      = 16,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              one_byte,
    input  logic              two_bytes,
    input  logic              four_bytes,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WIDTH-1:0]  data_out,
    output logic              err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               commit;
    logic               accept;
    logic               req_err;
    logic [2:0]         live_size;

    logic [IDX_W+1:0]   cap_addr;
    logic [WIDTH-1:0]   cap_data;
    logic               cap_wr;
    logic [2:0]         cap_size;

    logic [IDX_W+1:0]   acc_addr;
    logic [WIDTH-1:0]   acc_data;
    logic               acc_wr;
    logic [2:0]         acc_size;
    logic [IDX_W-1:0]   acc_idx;
    logic [1:0]         acc_lane;
    logic [WIDTH-1:0]   rd_word;
    logic [WIDTH-1:0]   wr_word;
    logic [WIDTH-1:0]   rd_data;

    logic [WIDTH-1:0]   mem [DEPTH_WORDS];
    logic [WIDTH-1:0]   data_q;
    logic               err_q;

    assign live_size  = {four_bytes, two_bytes, one_byte};
    assign accept     = req_valid && (state_q == IDLE);
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign data_out   = data_q;
    assign err        = err_q;

    always_comb begin
        req_err = 1'b0;
        if (!(live_size == 3'b001 || live_size == 3'b010 || live_size == 3'b100))
            req_err = 1'b1;
        if (two_bytes && addr[0])
            req_err = 1'b1;
        if (four_bytes && (addr[1:0] != 2'b00))
            req_err = 1'b1;
        if (32'(addr) >= 32'(4 * DEPTH_WORDS))
            req_err = 1'b1;
    end

    // With no wait states the commit happens on the acceptance edge, so the live inputs are used directly.
    assign acc_addr = (state_q == IDLE) ? addr[IDX_W+1:0] : cap_addr;
    assign acc_data = (state_q == IDLE) ? data_in : cap_data;
    assign acc_wr   = (state_q == IDLE) ? req_wr : cap_wr;
    assign acc_size = (state_q == IDLE) ? live_size : cap_size;
    assign acc_idx  = acc_addr[IDX_W+1:2];
    assign acc_lane = acc_addr[1:0];
    assign rd_word  = mem[acc_idx];

    always_comb begin
        wr_word = rd_word;
        rd_data = '0;
        if (acc_size[0]) begin
            wr_word[{acc_lane, 3'b000} +: 8] = acc_data[7:0];
            rd_data[7:0]                     = rd_word[{acc_lane, 3'b000} +: 8];
        end else if (acc_size[1]) begin
            wr_word[{acc_lane[1], 4'b0000} +: 16] = acc_data[15:0];
            rd_data[15:0]                         = rd_word[{acc_lane[1], 4'b0000} +: 16];
        end else if (acc_size[2]) begin
            wr_word = acc_data;
            rd_data = rd_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        state_d = RESP;
                    end else if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (resp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_addr <= '0;
            cap_data <= '0;
            cap_wr   <= 1'b0;
            cap_size <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                cap_addr <= addr[IDX_W+1:0];
                cap_data <= data_in;
                cap_wr   <= req_wr;
                cap_size <= live_size;
                if (req_err) begin
                    err_q  <= 1'b1;
                    data_q <= '0;
                end
            end
            if (commit) begin
                err_q  <= 1'b0;
                data_q <= acc_wr ? '0 : rd_data;
            end
            if ((state_q == RESP) && resp_ready) begin
                err_q  <= 1'b0;
                data_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++)
                mem[i] <= '0;
        end else if (commit && acc_wr) begin
            mem[acc_idx] <= wr_word;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed bench with a byte-array reference model
// Model tracks storage as bytes and derives err/data from the access rules.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_wr;
    logic [15:0] addr;
    logic [31:0] data_in;
    logic        one_byte, two_bytes, four_bytes;
    logic        resp_valid, resp_ready, err;
    logic [31:0] data_out;

    logic        b_req_valid, b_req_ready, b_req_wr;
    logic [15:0] b_addr;
    logic [31:0] b_data_in;
    logic        b_one_byte, b_two_bytes, b_four_bytes;
    logic        b_resp_valid, b_resp_ready, b_err;
    logic [31:0] b_data_out;

    data_mem_responder #(.WIDTH(32), .ADDR_W(16), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .addr(addr), .data_in(data_in), .one_byte(one_byte), .two_bytes(two_bytes),
        .four_bytes(four_bytes), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .data_out(data_out), .err(err)
    );

    data_mem_responder #(.WIDTH(32), .ADDR_W(16), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0w (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wr(b_req_wr),
        .addr(b_addr), .data_in(b_data_in), .one_byte(b_one_byte), .two_bytes(b_two_bytes),
        .four_bytes(b_four_bytes), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .data_out(b_data_out), .err(b_err)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_data = '0;
    logic        exp_err = 1'b0;
    logic [7:0]  mem_b [4096];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, want, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 4096; i++) mem_b[i] = 8'h00;
    endfunction

    function automatic void model_req(input bit wr, input logic [15:0] a, input logic [31:0] d,
                                      input logic [2:0] s, output bit e, output logic [31:0] q);
        int n;
        q = '0;
        case (s)
            3'b001:  n = 1;
            3'b010:  n = 2;
            3'b100:  n = 4;
            default: n = 0;
        endcase
        e = (n == 0);
        if (!e) e = ((int'(a) % n) != 0) || (int'(a) >= 4 * 1024);
        if (!e) begin
            for (int i = 0; i < n; i++) begin
                if (wr) mem_b[int'(a) + i] = d[8*i +: 8];
                else    q[8*i +: 8] = mem_b[int'(a) + i];
            end
        end
    endfunction

    task automatic do_req(input bit wr, input logic [15:0] a, input logic [31:0] d, input logic [2:0] s,
                          input int hold, input bit early, output logic [31:0] q, output logic e);
        int          n;
        int          t;
        bit          me;
        logic [31:0] mq;
        @(negedge clk);
        req_valid = 1'b1; req_wr = wr; addr = a; data_in = d;
        {four_bytes, two_bytes, one_byte} = s;
        resp_ready = early;
        t = 0;
        while (!req_ready && t < 20) begin @(negedge clk); t++; end
        check("ready_before_accept", 32'(req_ready), 1);
        @(posedge clk);
        model_req(wr, a, d, s, me, mq);
        exp_err = me; exp_data = mq;
        #1;
        req_valid = 1'b0; addr = 16'($urandom); data_in = $urandom; req_wr = ~wr;
        {four_bytes, two_bytes, one_byte} = 3'($urandom);
        n = 1;
        while (!resp_valid && n < 30) begin @(posedge clk); #1; n++; end
        check("latency", 32'(n), me ? 32'd1 : 32'd3);
        q = data_out; e = err;
        if (early) begin
            @(posedge clk); #1;
            check("pulse_drop", 32'(resp_valid), 0);
            resp_ready = 1'b0;
        end else begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                req_valid = 1'b1;
                #1 check("ready_in_resp", 32'(req_ready), 0);
                @(posedge clk); #1;
                req_valid = 1'b0;
                check("valid_held", 32'(resp_valid), 1);
            end
            @(negedge clk);
            resp_ready = 1'b1;
            @(posedge clk); #1;
            resp_ready = 1'b0;
            check("resp_exit", 32'(resp_valid), 0);
            if (hold > 0) begin
                @(posedge clk); #1;
                check("not_queued", 32'(resp_valid), 0);
            end
        end
        check("ready_after_exit", 32'(req_ready), 1);
    endtask

    task automatic req_nowait(input bit wr, input logic [15:0] a, input logic [31:0] d,
                              input logic [2:0] s, output logic [31:0] q);
        @(negedge clk);
        b_req_valid = 1'b1; b_req_wr = wr; b_addr = a; b_data_in = d;
        {b_four_bytes, b_two_bytes, b_one_byte} = s;
        b_resp_ready = 1'b1;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        check("w0_latency", 32'(b_resp_valid), 1);
        check("w0_err", 32'(b_err), 0);
        q = b_data_out;
        @(posedge clk); #1;
        check("w0_pulse", 32'(b_resp_valid), 0);
        b_resp_ready = 1'b0;
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            check("ready_valid_excl", 32'(req_ready & resp_valid), 0);
            if (resp_valid) begin
                check("resp_data", data_out, exp_data);
                check("resp_err", 32'(err), 32'(exp_err));
            end else begin
                check("idle_data", data_out, 0);
                check("idle_err", 32'(err), 0);
            end
        end
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] a;
        logic [2:0]  s;
    } err_vec_t;

    task automatic run_main();
        logic [31:0] q;
        logic        e;
        err_vec_t    ev [7];
        ev[0] = '{1'b1, 16'h0012, 3'b100};
        ev[1] = '{1'b0, 16'h0011, 3'b010};
        ev[2] = '{1'b0, 16'h1000, 3'b100};
        ev[3] = '{1'b1, 16'h1000, 3'b001};
        ev[4] = '{1'b0, 16'h0010, 3'b011};
        ev[5] = '{1'b0, 16'h0010, 3'b000};
        ev[6] = '{1'b1, 16'h0010, 3'b111};

        #2;
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_data_out", data_out, 0);
        check("rst_err", 32'(err), 0);
        @(negedge clk);
        rst = 1'b1;

        do_req(1'b1, 16'h0010, 32'hDEADBEEF, 3'b100, 0, 1'b0, q, e);
        check("wr_word_err", 32'(e), 0);
        check("wr_word_data", q, 0);
        do_req(1'b0, 16'h0010, 32'h0, 3'b100, 0, 1'b0, q, e);
        check("rd_word", q, 32'hDEADBEEF);
        do_req(1'b1, 16'h0013, 32'h000000AA, 3'b001, 0, 1'b0, q, e);
        do_req(1'b0, 16'h0010, 32'h0, 3'b100, 0, 1'b0, q, e);
        check("rd_after_byte", q, 32'hAAADBEEF);
        do_req(1'b0, 16'h0012, 32'h0, 3'b010, 0, 1'b0, q, e);
        check("rd_half_hi", q, 32'h0000AAAD);

        for (int i = 0; i < 7; i++) begin
            do_req(ev[i].wr, ev[i].a, 32'h55555555, ev[i].s, 0, 1'b0, q, e);
            check("err_flag", 32'(e), 1);
            check("err_data", q, 0);
        end
        do_req(1'b0, 16'h0010, 32'h0, 3'b100, 0, 1'b0, q, e);
        check("unchanged_after_err", q, 32'hAAADBEEF);

        do_req(1'b0, 16'h0010, 32'h0, 3'b100, 5, 1'b0, q, e);
        check("rd_held", q, 32'hAAADBEEF);
        do_req(1'b0, 16'h0013, 32'h0, 3'b001, 0, 1'b1, q, e);
        check("rd_byte_pulse", q, 32'h000000AA);

        do_req(1'b1, 16'h0016, 32'hFFFF5678, 3'b010, 0, 1'b0, q, e);
        do_req(1'b1, 16'h0014, 32'h1234569A, 3'b001, 0, 1'b1, q, e);
        do_req(1'b0, 16'h0014, 32'h0, 3'b100, 0, 1'b0, q, e);
        check("rd_lanes", q, 32'h5678009A);
        do_req(1'b0, 16'h0014, 32'h0, 3'b010, 0, 1'b0, q, e);
        check("rd_half_lo", q, 32'h0000009A);
        do_req(1'b1, 16'h0FFC, 32'h0BADF00D, 3'b100, 0, 1'b0, q, e);
        do_req(1'b0, 16'h0FFC, 32'h0, 3'b100, 0, 1'b0, q, e);
        check("rd_last_word", q, 32'h0BADF00D);

        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; addr = 16'h0020; data_in = 32'h12345678;
        {four_bytes, two_bytes, one_byte} = 3'b100;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("in_wait", 32'(req_ready), 0);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("abort_req_ready", 32'(req_ready), 1);
        check("abort_resp_valid", 32'(resp_valid), 0);
        check("abort_data_out", data_out, 0);
        check("abort_err", 32'(err), 0);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        do_req(1'b0, 16'h0020, 32'h0, 3'b100, 0, 1'b0, q, e);
        check("rd_aborted", q, 32'h00000000);
        do_req(1'b0, 16'h0010, 32'h0, 3'b100, 0, 1'b0, q, e);
        check("rd_cleared", q, 32'h00000000);

        req_nowait(1'b1, 16'h0040, 32'hCAFEF00D, 3'b100, q);
        req_nowait(1'b0, 16'h0040, 32'h0, 3'b100, q);
        check("w0_rd_word", q, 32'hCAFEF00D);
        req_nowait(1'b0, 16'h0041, 32'h0, 3'b001, q);
        check("w0_rd_byte", q, 32'h000000F0);
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_wr = 1'b0; addr = '0; data_in = '0;
        one_byte = 1'b0; two_bytes = 1'b0; four_bytes = 1'b0; resp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_wr = 1'b0; b_addr = '0; b_data_in = '0;
        b_one_byte = 1'b0; b_two_bytes = 1'b0; b_four_bytes = 1'b0; b_resp_ready = 1'b0;
        model_clear();
        fork
            compare_loop();
            run_main();
            begin
                #200000;
                $display("FAIL watchdog: got timeout want completion");
                $fatal(1, "watchdog expired");
            end
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
